// File: rtl/ir_pkg.sv
// Shared definitions for the IR transmit scheduler and related blocks.
// Holds the scheduler state encoding and default payload/guard constants.
package ir_pkg;

   localparam int unsigned IR_DATA_W       = 8;
   localparam int unsigned IR_GUARD_CYCLES = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      GUARD
   } ir_state_t;

endpackage

// File: rtl/ir_tx_scheduler_if.sv
// Requester/transceiver-side bundle of the IR transmit scheduler.
// master: requesters and transceiver (drive req, req_data, tx_busy)
// slave : scheduler (drives grant, done, err, tx_start, tx_data, rx_blank)
interface ir_tx_scheduler_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = ir_pkg::IR_DATA_W
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      err;
   logic                      tx_start;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_busy;
   logic                      rx_blank;

   modport master (
      output req, req_data, tx_busy,
      input  grant, done, err, tx_start, tx_data, rx_blank
   );

   modport slave (
      input  req, req_data, tx_busy,
      output grant, done, err, tx_start, tx_data, rx_blank
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the slot after
// last_grant is bit 0, isolate the lowest set bit, rotate back.
// Ports: req (request vector), last_grant (index of previous winner),
//        grant_onehot (winner, all-zero when no request).
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant_onehot
);

   logic [NUM_REQ-1:0] req_rot;
   logic [NUM_REQ-1:0] pick_rot;
   int unsigned        idx;

   always_comb begin
      req_rot      = '0;
      grant_onehot = '0;
      idx          = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx        = (i + 32'(last_grant) + 1) % NUM_REQ;
         req_rot[i] = req[idx[IDX_W-1:0]];
      end
      // lowest set bit of the rotated vector is the next requester upward
      pick_rot = req_rot & (~req_rot + NUM_REQ'(1));
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (i + 32'(last_grant) + 1) % NUM_REQ;
         grant_onehot[idx[IDX_W-1:0]] = pick_rot[i];
      end
   end

endmodule

// File: rtl/ir_tx_scheduler.sv
// Round-robin scheduler sharing one half-duplex IR transmit path among
// NUM_REQ requesters: one frame at a time, start timeout, turnaround guard,
// receive blanking while our own frame is on air.
// Ports: clock, reset_n (async active-low),
//        bus (slave): req/req_data in, grant/done/err out,
//        tx_start/tx_data/tx_busy to the transceiver, rx_blank out.
module ir_tx_scheduler
   import ir_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_W        = IR_DATA_W,
   parameter int unsigned GUARD_CYCLES  = IR_GUARD_CYCLES,
   parameter int unsigned START_TIMEOUT = 8
) (
   input logic             clock,
   input logic             reset_n,
   ir_tx_scheduler_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned TO_W   = $clog2(START_TIMEOUT + 1);
   localparam int unsigned TO_W1  = TO_W + 1;
   localparam int unsigned GD_W   = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam int unsigned GD_W1  = GD_W + 1;

   ir_state_t          state, state_nxt;
   logic [TO_W-1:0]    to_cnt;
   logic [GD_W-1:0]    gd_cnt;
   logic [TO_W1-1:0]   to_inc;
   logic [GD_W1-1:0]   gd_inc;
   logic               timeout_hit;
   logic               guard_last;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic [IDX_W-1:0]   last_grant, last_grant_nxt;

   logic [NUM_REQ-1:0] grant_q, grant_nxt;
   logic [NUM_REQ-1:0] done_q, done_nxt;
   logic               err_q, err_nxt;
   logic               tx_start_q, tx_start_nxt;
   logic [DATA_W-1:0]  tx_data_q, tx_data_nxt;
   logic               rx_blank_q, rx_blank_nxt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req          (bus.req),
      .last_grant   (last_grant),
      .grant_onehot (arb_grant)
   );

   // winner index for payload select and pointer update
   always_comb begin
      arb_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) arb_idx = IDX_W'(i);
      end
   end

   // counter limits evaluated on the incremented value so the exit cycle is exact
   assign to_inc      = {1'b0, to_cnt} + TO_W1'(1);
   assign gd_inc      = {1'b0, gd_cnt} + GD_W1'(1);
   assign timeout_hit = !bus.tx_busy && (to_inc >= TO_W1'(START_TIMEOUT));
   assign guard_last  = gd_inc >= GD_W1'(GUARD_CYCLES);

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (|bus.req) state_nxt = START;
         START:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (bus.tx_busy)      state_nxt = WAIT_DONE;
            else if (timeout_hit) state_nxt = GUARD;
         end
         WAIT_DONE: if (!bus.tx_busy) state_nxt = GUARD;
         GUARD:     if (guard_last) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // output logic: next values of the registered outputs
   always_comb begin
      grant_nxt      = grant_q;
      done_nxt       = '0;
      err_nxt        = 1'b0;
      tx_data_nxt    = tx_data_q;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (|bus.req) begin
               grant_nxt      = arb_grant;
               tx_data_nxt    = bus.req_data[arb_idx*DATA_W +: DATA_W];
               last_grant_nxt = arb_idx;
            end
         end
         WAIT_BUSY: begin
            if (timeout_hit) begin
               done_nxt  = grant_q;
               err_nxt   = 1'b1;
               grant_nxt = '0;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               done_nxt  = grant_q;
               grant_nxt = '0;
            end
         end
         default: ;
      endcase
      tx_start_nxt = (state_nxt == START);
      rx_blank_nxt = (state_nxt != IDLE);
   end

   // output registers and round-robin pointer (reset pointer favours requester 0)
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant_q    <= '0;
         done_q     <= '0;
         err_q      <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         rx_blank_q <= 1'b0;
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else begin
         grant_q    <= grant_nxt;
         done_q     <= done_nxt;
         err_q      <= err_nxt;
         tx_start_q <= tx_start_nxt;
         tx_data_q  <= tx_data_nxt;
         rx_blank_q <= rx_blank_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // saturating timeout and guard counters, cleared outside their states
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
         gd_cnt <= '0;
      end else begin
         if (state != WAIT_BUSY)                     to_cnt <= '0;
         else if (to_cnt < TO_W'(START_TIMEOUT))     to_cnt <= to_cnt + TO_W'(1);
         if (state != GUARD)                         gd_cnt <= '0;
         else if (gd_cnt < GD_W'(GUARD_CYCLES))      gd_cnt <= gd_cnt + GD_W'(1);
      end
   end

   assign bus.grant    = grant_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.rx_blank = rx_blank_q;

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
Round-robin scheduler that shares one half-duplex IR transceiver transmit path among NUM_REQ requesters. It starts one frame at a time and tracks its progress through the transceiver busy flag. After each frame it holds a turnaround guard. It blanks the receive path during its own transmission, so the loopback echo on rx_port is not taken as incoming data. Sits between the application-side requesters and ir_transceiver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, payload width per frame
GUARD_CYCLES, 16, idle clocks after a frame before the next grant (0 = no guard)
START_TIMEOUT, 8, clocks allowed between tx_start and tx_busy rising

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester frame request, level; must be held until matching done bit pulses
req_data  in  NUM_REQ*DATA_W  payload; requester i occupies bits [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  one-hot; bit of the requester currently owning the transmitter
done  out  NUM_REQ  one-cycle pulse to the granted requester when its frame completes or fails
err  out  1  one-cycle pulse, coincident with done, when the start timeout expires
tx_start  out  1  one-cycle start strobe to the transceiver
tx_data  out  DATA_W  payload to the transceiver; stable from tx_start until done
tx_busy  in  1  transceiver busy, high while a frame is shifting out
rx_blank  out  1  high while received data must be ignored

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; grant, done, err, tx_start and rx_blank are 0; tx_data=0.
  - Round-robin pointer resets so requester 0 has highest priority.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE:
  - With any req bit set, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap-around.
  - Register grant (one-hot), latch that requester's req_data into tx_data, update last_grant, then go to START.
  - Latency is one clock from the req bit being sampled to the grant being registered.
- START: tx_start=1 for exactly this one cycle; go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else increment the counter. When the counter reaches START_TIMEOUT, pulse done[granted] and err, then go to GUARD.
- WAIT_DONE: when tx_busy=0, pulse done[granted] for one cycle and go to GUARD.
- GUARD:
  - Count GUARD_CYCLES clocks, then go to IDLE.
  - grant drops on entry to GUARD.
  - With GUARD_CYCLES=0, go from done straight to IDLE the next cycle.
- rx_blank is 1 in the START, WAIT_BUSY, WAIT_DONE and GUARD states, and 0 only in IDLE.
- A requester dropping req mid-frame does not abort; the frame completes and done still pulses.
- A requester holding req after its done is rescheduled only after the other pending requesters (fairness).
- req changes during non-IDLE states are ignored until the next return to IDLE.
- tx_busy already high in IDLE or GUARD: ignored. A frame must see a fresh tx_busy after its own tx_start.
- Width rules: the timeout and guard counters are sized by $clog2(max+1) and saturate, never wrap.
- Reset mid-frame:
  - All outputs go to reset values immediately; no done pulse is issued.
  - Requesters must re-request.

Decomposition:
- Shared package ir_pkg holds:
  - the state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD);
  - the default constants IR_DATA_W=8 and IR_GUARD_CYCLES=16.
- One natural sub-module: rr_arbiter (parameter NUM_REQ; inputs req and last_grant; output grant_onehot). It is purely combinational rotate-priority-rotate and is reusable by the future receive-side dispatcher.
- Counters and the FSM stay in ir_tx_scheduler.

Test Plan:
- Single request, with a bench transceiver model holding tx_busy high for 20 cycles after tx_start:
  - Stimulus: req=4'b0010, req_data[15:8]=8'hA5.
  - Response: grant=0010 one cycle later; one tx_start pulse; tx_data=A5 held; done[1] pulses on the tx_busy fall; rx_blank high from START until 16 cycles after done.
- All four requesting from reset (req=1111, held): grants in order 0,1,2,3,0, each separated by a 16-cycle guard; never two grant bits set.
- Fairness: req=0011 held; requester 0 completes; grant goes to 1 next, not 0.
- Start timeout: the transceiver model never raises tx_busy. Required response: exactly 8 cycles after the WAIT_BUSY entry, done[granted] and err pulse together; the guard runs, then IDLE.
- Reset mid-frame: assert reset_n=0 while in WAIT_DONE. Required response: grant, tx_start and rx_blank are 0 immediately with no done pulse; after release, req=1000 is granted with priority restarting at 0.
- GUARD_CYCLES=0 and a loopback bench (rx_port driven from tx_port): back-to-back frames with exactly one IDLE cycle between done and the next grant; rx_blank is high for every cycle in which tx_port toggles.
